// File: rtl/mem_stage_lsu_if.sv
// Bundle of the MEM-stage load/store request port, the response port and the
// byte-wide data-memory port. The LSU is the master; the pipeline plus the
// memory together form the slave side.
//
// Handshakes:
//   request : a request transfers on a rising edge where req_valid=1, at least
//             one of req_read/req_write=1 and req_ready=1. While req_ready=0 the
//             pipeline holds its request unchanged.
//   response: resp_valid is a single-cycle pulse; there is no back-pressure.
//   memory  : a byte beat completes on a rising edge where mem_req=1 and
//             mem_ack=1; mem_addr/mem_we/mem_wdata are stable until then and
//             mem_ack is meaningless while mem_req=0.
interface mem_stage_lsu_if #(
    parameter int ADDR_W   = 10,
    parameter int RESULT_W = 64
);
    logic                req_valid;
    logic                req_read;
    logic                req_write;
    logic                req_byte;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         req_wdata;
    logic                req_ready;
    logic                resp_valid;
    logic [RESULT_W-1:0] resp_rdata;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_wdata;
    logic                mem_ack;
    logic [7:0]          mem_rdata;
    // FSM state of the LSU, for observation only
    logic [1:0]          dbg_state;

    modport master (
        input  req_valid, req_read, req_write, req_byte, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output dbg_state
    );

    modport slave (
        output req_valid, req_read, req_write, req_byte, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  dbg_state
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one load/store, stalls the pipeline while
// it runs one byte beat per memory handshake (big-endian order), and returns a
// zero-extended load result.
module mem_stage_lsu #(
    parameter int ADDR_W   = 10,
    parameter int RESULT_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_stage_lsu_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                byte_q, byte_d;
    logic                store_q, store_d;
    logic [23:0]         asm_q, asm_d;
    logic [RESULT_W-1:0] rdata_q, rdata_d;

    logic                accept;
    logic                beat_ack;
    logic                last_beat;
    logic [1:0]          beat_off;

    // Decode of the request/beat events; a byte access is a single beat at A+3
    always_comb begin
        accept    = (state_q == ST_IDLE) && bus.req_valid && (bus.req_read || bus.req_write);
        beat_ack  = (state_q == ST_BUSY) && bus.mem_ack;
        last_beat = byte_q || (k_q == 2'd3);
        beat_off  = byte_q ? 2'd3 : k_q;
    end

    // FSM next state and control outputs
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = store_q;
                if (beat_ack && last_beat) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.resp_valid = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next state: capture on acceptance, shift/advance on each beat ack
    always_comb begin
        k_d     = k_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        byte_d  = byte_q;
        store_d = store_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        if (accept) begin
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            byte_d  = bus.req_byte;
            // write wins when both ops are asserted
            store_d = bus.req_write;
            k_d     = 2'd0;
            asm_d   = 24'd0;
        end else if (beat_ack) begin
            k_d   = k_q + 2'd1;
            asm_d = {asm_q[15:0], bus.mem_rdata};
            // asm_q is cleared at acceptance, so a byte load lands as {0, b3}
            if (last_beat && !store_q) rdata_d = RESULT_W'({asm_q, bus.mem_rdata});
        end
    end

    // Memory address/data for the current beat; stable for the whole beat
    always_comb begin
        bus.mem_addr  = addr_q + ADDR_W'(beat_off);
        bus.mem_wdata = wdata_q[7:0];
        if (!byte_q) begin
            case (k_q)
                2'd0:    bus.mem_wdata = wdata_q[31:24];
                2'd1:    bus.mem_wdata = wdata_q[23:16];
                2'd2:    bus.mem_wdata = wdata_q[15:8];
                default: bus.mem_wdata = wdata_q[7:0];
            endcase
        end
        bus.resp_rdata = rdata_q;
        bus.dbg_state  = state_q;
    end

    // State registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            byte_q  <= 1'b0;
            store_q <= 1'b0;
            asm_q   <= 24'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            byte_q  <= byte_d;
            store_q <= store_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end
endmodule
